// File: rtl/haar_dwt_2level_if.sv
// Stream bundle for the two-level Haar analysis stage: ADC input,
// GPIO config word, and the L1/L2/selected-detail coefficient outputs.
interface haar_dwt_2level_if #(
    parameter int ADC_WIDTH = 14
);
    logic signed [ADC_WIDTH-1:0] adc_data;
    logic                        adc_valid;
    logic [31:0]                 gpio_cfg;
    logic signed [ADC_WIDTH-1:0] approx_l1;
    logic signed [ADC_WIDTH-1:0] detail_l1;
    logic                        valid_l1;
    logic signed [ADC_WIDTH-1:0] approx_l2;
    logic signed [ADC_WIDTH-1:0] detail_l2;
    logic                        valid_l2;
    logic signed [ADC_WIDTH-1:0] detail_level;
    logic                        detail_valid;

    modport master (
        output adc_data, adc_valid, gpio_cfg,
        input  approx_l1, detail_l1, valid_l1,
        input  approx_l2, detail_l2, valid_l2,
        input  detail_level, detail_valid
    );

    modport slave (
        input  adc_data, adc_valid, gpio_cfg,
        output approx_l1, detail_l1, valid_l1,
        output approx_l2, detail_l2, valid_l2,
        output detail_level, detail_valid
    );
endinterface

// File: rtl/haar_dwt_2level.sv
// Streaming two-level Haar analysis (decimate by 2 per level).
// Define DWT_ROUND_EN for round-half-up with saturation instead of floor.
module haar_dwt_2level #(
    parameter int ADC_WIDTH = 14
) (
    input logic               clk,
    input logic               rst,
    haar_dwt_2level_if.slave  bus
);
    localparam int W = ADC_WIDTH;
    typedef logic signed [W-1:0] coef_t;

`ifdef DWT_ROUND_EN
    localparam logic signed [W+1:0] ONE  = {{(W+1){1'b0}}, 1'b1};
    localparam logic signed [W+1:0] SMAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SMIN = {3'b111, {(W-1){1'b0}}};

    function automatic coef_t haar(coef_t p, coef_t q, logic sub);
        logic signed [W+1:0] pe;
        logic signed [W+1:0] qe;
        logic signed [W+1:0] t;
        pe = {{2{p[W-1]}}, p};
        qe = {{2{q[W-1]}}, q};
        t  = (sub ? pe - qe : pe + qe) + ONE;
        t  = t >>> 1;
        if (t > SMAX) t = SMAX;
        if (t < SMIN) t = SMIN;
        return coef_t'(t);
    endfunction
`else
    // One guard bit is enough: the halved sum/difference always fits W bits.
    function automatic coef_t haar(coef_t p, coef_t q, logic sub);
        logic signed [W:0] pe;
        logic signed [W:0] qe;
        logic signed [W:0] t;
        pe = {p[W-1], p};
        qe = {q[W-1], q};
        t  = sub ? pe - qe : pe + qe;
        return coef_t'(t >>> 1);
    endfunction
`endif

    logic  en, sel;
    logic  ph1, ph2;
    coef_t x0_1, x0_2;
    coef_t a1, d1, a2, d2, dl;
    logic  v1, v2, dv;

    assign en  = bus.gpio_cfg[31];
    assign sel = bus.gpio_cfg[30];

    always_ff @(posedge clk) begin
        if (rst) begin
            ph1  <= 1'b0;
            ph2  <= 1'b0;
            x0_1 <= '0;
            x0_2 <= '0;
            a1   <= '0;
            d1   <= '0;
            a2   <= '0;
            d2   <= '0;
            dl   <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            dv   <= 1'b0;
        end else if (!en) begin
            // Coefficients hold; pairing state restarts on an even sample.
            ph1  <= 1'b0;
            ph2  <= 1'b0;
            x0_1 <= '0;
            x0_2 <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            dv   <= 1'b0;
        end else begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            if (bus.adc_valid) begin
                ph1 <= ~ph1;
                if (!ph1) begin
                    x0_1 <= bus.adc_data;
                end else begin
                    a1 <= haar(x0_1, bus.adc_data, 1'b0);
                    d1 <= haar(x0_1, bus.adc_data, 1'b1);
                    v1 <= 1'b1;
                end
            end
            if (v1) begin
                ph2 <= ~ph2;
                if (!ph2) begin
                    x0_2 <= a1;
                end else begin
                    a2 <= haar(x0_2, a1, 1'b0);
                    d2 <= haar(x0_2, a1, 1'b1);
                    v2 <= 1'b1;
                end
            end
            dv <= sel ? v2 : v1;
            if (sel ? v2 : v1) dl <= sel ? d2 : d1;
        end
    end

    assign bus.approx_l1    = a1;
    assign bus.detail_l1    = d1;
    assign bus.valid_l1     = v1;
    assign bus.approx_l2    = a2;
    assign bus.detail_l2    = d2;
    assign bus.valid_l2     = v2;
    assign bus.detail_level = dl;
    assign bus.detail_valid = dv;
endmodule

// File: tb/tb_haar_dwt_2level.sv
// Directed bench for haar_dwt_2level with a scoreboard of expected
// L1, L2 and selected-detail coefficients.
module tb_haar_dwt_2level;
    localparam logic [31:0] EN  = 32'h8000_0000;
    localparam logic [31:0] SEL = 32'hC000_0000;
    localparam logic [31:0] OFF = 32'h0000_0000;

    typedef struct {
        logic signed [13:0] a;
        logic signed [13:0] d;
    } pair_t;

    logic clk;
    logic rst;
    haar_dwt_2level_if #(.ADC_WIDTH(14)) bus ();

    haar_dwt_2level #(.ADC_WIDTH(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    pair_t q1[$];
    pair_t q2[$];
    logic signed [13:0] qd[$];

    // reference model state
    bit m_ph1, m_ph2;
    int m_x0_1, m_x0_2;
    bit p1, p2;
    int p1_a, p1_d, p2_d;
    int m_last_a1;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [13:0] href(int p, int q, bit sub);
        int s;
        s = sub ? p - q : p + q;
`ifdef DWT_ROUND_EN
        s = s + 1;
`endif
        s = s >>> 1;
`ifdef DWT_ROUND_EN
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
`endif
        return s[13:0];
    endfunction

    task automatic step(input int x, input bit v, input bit r,
                        input logic [31:0] cfg);
        bit n1, n2;
        int na, nd, n2d;
        pair_t pr;
        bus.adc_data  = x[13:0];
        bus.adc_valid = v;
        bus.gpio_cfg  = cfg;
        rst           = r;
        n1 = 0;
        n2 = 0;
        na = 0;
        nd = 0;
        n2d = 0;
        if (r || !cfg[31]) begin
            m_ph1 = 0;
            m_ph2 = 0;
            m_x0_1 = 0;
            m_x0_2 = 0;
            if (r) m_last_a1 = 0;
        end else begin
            if (cfg[30] && p2) qd.push_back(p2_d[13:0]);
            if (!cfg[30] && p1) qd.push_back(p1_d[13:0]);
            if (p1) begin
                if (!m_ph2) begin
                    m_x0_2 = p1_a;
                    m_ph2 = 1;
                end else begin
                    pr.a = href(m_x0_2, p1_a, 0);
                    pr.d = href(m_x0_2, p1_a, 1);
                    q2.push_back(pr);
                    n2 = 1;
                    n2d = int'(pr.d);
                    m_ph2 = 0;
                end
            end
            if (v) begin
                if (!m_ph1) begin
                    m_x0_1 = x;
                    m_ph1 = 1;
                end else begin
                    pr.a = href(m_x0_1, x, 0);
                    pr.d = href(m_x0_1, x, 1);
                    q1.push_back(pr);
                    n1 = 1;
                    na = int'(pr.a);
                    nd = int'(pr.d);
                    m_last_a1 = na;
                    m_ph1 = 0;
                end
            end
        end
        p1 = n1;
        p1_a = na;
        p1_d = nd;
        p2 = n2;
        p2_d = n2d;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        pair_t e;
        if (bus.valid_l1 === 1'b1) begin
            if (q1.size() == 0) chk("l1_extra_strobe", 0, 1);
            else begin
                e = q1.pop_front();
                chk("approx_l1", bus.approx_l1, e.a);
                chk("detail_l1", bus.detail_l1, e.d);
            end
        end
        if (bus.valid_l2 === 1'b1) begin
            if (q2.size() == 0) chk("l2_extra_strobe", 0, 1);
            else begin
                e = q2.pop_front();
                chk("approx_l2", bus.approx_l2, e.a);
                chk("detail_l2", bus.detail_l2, e.d);
            end
        end
        if (bus.detail_valid === 1'b1) begin
            if (qd.size() == 0) chk("dl_extra_strobe", 0, 1);
            else chk("detail_level", bus.detail_level, qd.pop_front());
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a1"}, bus.approx_l1, 0);
        chk({tag, "_d1"}, bus.detail_l1, 0);
        chk({tag, "_v1"}, bus.valid_l1, 0);
        chk({tag, "_a2"}, bus.approx_l2, 0);
        chk({tag, "_d2"}, bus.detail_l2, 0);
        chk({tag, "_v2"}, bus.valid_l2, 0);
        chk({tag, "_dl"}, bus.detail_level, 0);
        chk({tag, "_dv"}, bus.detail_valid, 0);
    endtask

    initial begin
        bus.adc_data = '0;
        bus.adc_valid = 1'b0;
        bus.gpio_cfg = EN;
        rst = 1'b1;
        m_ph1 = 0; m_ph2 = 0; m_x0_1 = 0; m_x0_2 = 0;
        p1 = 0; p2 = 0; p1_a = 0; p1_d = 0; p2_d = 0; m_last_a1 = 0;

        // reset state
        step(0, 0, 1, EN);
        step(0, 0, 1, EN);
        chk_all_zero("reset");

        // first pair, latency and hold
        step(100, 1, 0, EN);
        chk("t1_no_early_v1", bus.valid_l1, 0);
        step(60, 1, 0, EN);
        chk("t1_v1", bus.valid_l1, 1);
        chk("t1_a1", bus.approx_l1, 80);
        chk("t1_d1", bus.detail_l1, 20);
        chk("t1_v2", bus.valid_l2, 0);
        step(0, 0, 0, EN);
        chk("t1_v1_one_cycle", bus.valid_l1, 0);
        step(0, 0, 0, EN);
        chk("t1_a1_hold", bus.approx_l1, 80);

        // two L1 pairs into one L2 pair, detail_level from L2
        step(0, 0, 1, SEL);
        step(100, 1, 0, SEL);
        step(60, 1, 0, SEL);
        step(20, 1, 0, SEL);
        step(40, 1, 0, SEL);
        chk("t2_a1", bus.approx_l1, 30);
        chk("t2_d1", bus.detail_l1, -10);
        chk("t2_v2_not_yet", bus.valid_l2, 0);
        step(0, 0, 0, SEL);
        chk("t2_v2", bus.valid_l2, 1);
        chk("t2_a2", bus.approx_l2, 55);
        chk("t2_d2", bus.detail_l2, 25);
        chk("t2_dv_not_yet", bus.detail_valid, 0);
        step(0, 0, 0, SEL);
        chk("t2_dv", bus.detail_valid, 1);
        chk("t2_dl", bus.detail_level, 25);
        step(0, 0, 0, SEL);
        chk("t2_dv_one_cycle", bus.detail_valid, 0);

        // negative rounding
        step(0, 0, 1, EN);
        step(-3, 1, 0, EN);
        step(0, 1, 0, EN);
`ifdef DWT_ROUND_EN
        chk("t3_a1", bus.approx_l1, -1);
        chk("t3_d1", bus.detail_l1, -1);
`else
        chk("t3_a1", bus.approx_l1, -2);
        chk("t3_d1", bus.detail_l1, -2);
`endif

        // extremes
        step(0, 0, 1, EN);
        step(8191, 1, 0, EN);
        step(-8192, 1, 0, EN);
`ifdef DWT_ROUND_EN
        chk("t4_a1", bus.approx_l1, 0);
`else
        chk("t4_a1", bus.approx_l1, -1);
`endif
        chk("t4_d1", bus.detail_l1, 8191);

        // disable mid-pair discards the held sample
        step(100, 1, 0, EN);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, OFF);
            chk("t5_v1_off", bus.valid_l1, 0);
            chk("t5_a1_hold", bus.approx_l1, m_last_a1);
        end
        step(10, 1, 0, EN);
        chk("t5_no_v1", bus.valid_l1, 0);
        step(20, 1, 0, EN);
        chk("t5_v1", bus.valid_l1, 1);
        chk("t5_a1", bus.approx_l1, 15);
        chk("t5_d1", bus.detail_l1, -5);

        // sparse ramp with resets mid-pair and a select change
        step(0, 0, 1, EN);
        for (int k = 0; k <= 128; k++) begin
            logic [31:0] c;
            c = (k >= 60) ? SEL : EN;
            if (k == 40) step(k - 64, 1, 1, c);
            else step(k - 64, 1, 0, c);
            if (k == 40) chk_all_zero("rst_odd");
            step(0, 0, 0, c);
            if (k == 6) begin
                step(0, 0, 1, c);
                chk_all_zero("rst_mid");
            end else begin
                step(0, 0, 0, c);
            end
        end

        // full-rate burst
        for (int k = 0; k < 32; k++) begin
            step(int'($urandom_range(16383)) - 8192, 1, 0, (k < 16) ? EN : SEL);
        end
        for (int k = 0; k < 6; k++) step(0, 0, 0, SEL);

        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        chk("qd_drained", qd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
